// File: rtl/isp_pkg.sv
// Shared ISP types: Bayer phase codes, mosaic FSM states and pixel payload.
package isp_pkg;
  localparam int PIX_W = 8;
  localparam int CNT_W = 32;
  localparam int PAY_W = PIX_W + 2 * CNT_W;

  typedef enum logic [1:0] {
    BAYER_GBRG = 2'd0,
    BAYER_BGGR = 2'd1,
    BAYER_RGGB = 2'd2,
    BAYER_GRBG = 2'd3
  } bayer_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LAST   = 2'd2
  } st_t;

  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } ch_t;

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } pix_t;

  // Site colour for phase pat at {y0,x0}.
  function automatic ch_t bayer_ch(
    input logic [1:0] pat,
    input logic       y0,
    input logic       x0
  );
    logic [1:0] i;
    i = {y0, x0};
    unique case (pat)
      BAYER_GBRG:
        return (i == 2'd1) ? CH_B :
               (i == 2'd2) ? CH_R : CH_G;
      BAYER_BGGR:
        return (i == 2'd0) ? CH_B :
               (i == 2'd3) ? CH_R : CH_G;
      BAYER_RGGB:
        return (i == 2'd0) ? CH_R :
               (i == 2'd3) ? CH_B : CH_G;
      default:
        return (i == 2'd1) ? CH_R :
               (i == 2'd2) ? CH_B : CH_G;
    endcase
  endfunction
endpackage

// File: rtl/bayer_skid_buf.sv
// One-entry skid buffer with registered output; in_ready comes from a flop.
module bayer_skid_buf #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  logic         full;
  logic [W-1:0] skid;
  logic         take;
  logic         load;

  assign in_ready = !full;
  assign take     = in_valid && !full;
  assign load     = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      full      <= 1'b0;
      skid      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      if (full) begin
        out_data  <= skid;
        out_valid <= 1'b1;
        full      <= 1'b0;
      end else if (take) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (take) begin
      skid <= in_data;
      full <= 1'b1;
    end
  end
endmodule

// File: rtl/bayer_mosaic.sv
// RGB raster to Bayer mosaic with skid-buffered valid/ready output.
// MOSAIC_TPG_EN adds an internal 8-bar colour test pattern on tpgEn.
module bayer_mosaic
  import isp_pkg::*;
#(
  parameter int width   = 1920,
  parameter int height  = 1080,
  parameter int pattern = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  input  logic        iValid,
  output logic        iReady,
  input  logic        tpgEn,
  output logic [7:0]  oData,
  output logic        oValid,
  input  logic        oReady,
  output logic [31:0] xCnt,
  output logic [31:0] yCnt,
  output logic        oDone
);
  localparam logic [31:0] X_LAST = 32'(width - 1);
  localparam logic [31:0] Y_LAST = 32'(height - 1);
  localparam logic [1:0]  PAT    = 2'(pattern);

  st_t         st;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        src_valid;
  logic [7:0]  r, g, b;
  logic        accept;
  logic        last_in;
  logic        out_last;
  ch_t         ch;
  pix_t        pix;
  pix_t        out_pix;

`ifdef MOSAIC_TPG_EN
  localparam logic [31:0] BAR_W =
    (width / 8 > 0) ? 32'(width / 8) : 32'd1;
  logic       tpg_mode;
  logic       tpg_sel;
  logic [2:0] k;

  // Mode latches only between frames; IDLE follows tpgEn live.
  assign tpg_sel   = (st == ST_IDLE) ? tpgEn : tpg_mode;
  assign k         = 3'(in_x / BAR_W);
  assign src_valid = tpg_sel || iValid;
  assign r = tpg_sel ? {8{k[2]}} : iR;
  assign g = tpg_sel ? {8{k[1]}} : iG;
  assign b = tpg_sel ? {8{k[0]}} : iB;

  always_ff @(posedge clk) begin
    if (!reset)
      tpg_mode <= 1'b0;
    else if (st == ST_IDLE)
      tpg_mode <= tpgEn;
  end
`else
  logic tpg_unused;
  assign tpg_unused = tpgEn;
  assign src_valid  = iValid;
  assign r = iR;
  assign g = iG;
  assign b = iB;
`endif

  assign accept   = src_valid && iReady;
  assign last_in  = (in_x == X_LAST) && (in_y == Y_LAST);
  assign ch       = bayer_ch(PAT, in_y[0], in_x[0]);
  assign out_last = (xCnt == X_LAST) && (yCnt == Y_LAST);

  always_comb begin
    pix.data = '0;
    pix.x    = in_x;
    pix.y    = in_y;
    unique case (1'b1)
      (ch == CH_R): pix.data = r;
      (ch == CH_G): pix.data = g;
      (ch == CH_B): pix.data = b;
      default:      pix.data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st   <= ST_IDLE;
      in_x <= '0;
      in_y <= '0;
    end else begin
      if (accept) begin
        if (in_x == X_LAST) begin
          in_x <= '0;
          in_y <= (in_y == Y_LAST) ? '0 : in_y + 32'd1;
        end else begin
          in_x <= in_x + 32'd1;
        end
      end
      unique case (st)
        ST_IDLE:
          if (accept) st <= last_in ? ST_LAST : ST_ACTIVE;
        ST_ACTIVE:
          if (accept && last_in) st <= ST_LAST;
        ST_LAST:
          // Next frame may already be flowing in behind the last pixel.
          if (oDone)
            st <= (accept || in_x != '0 || in_y != '0) ?
                  ST_ACTIVE : ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign oDone = (st == ST_LAST) && oValid && oReady && out_last;

  bayer_skid_buf #(
    .W(PAY_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  (pix),
    .in_valid (src_valid),
    .in_ready (iReady),
    .out_data (out_pix),
    .out_valid(oValid),
    .out_ready(oReady)
  );

  assign oData = out_pix.data;
  assign xCnt  = out_pix.x;
  assign yCnt  = out_pix.y;
endmodule

// File: tb/tb_bayer_mosaic.sv
// Scoreboard bench for bayer_mosaic: per-scenario tasks, queue of expected pixels.
module tb_bayer_mosaic;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  iR = '0, iG = '0, iB = '0;
  logic        iValid = 1'b0, oReady = 1'b1, tpgEn = 1'b0;

  logic [7:0]  a_d, b_d, c_d;
  logic        a_v, b_v, c_v, a_r, b_r, c_r;
  logic        a_done, b_done, c_done;
  logic [31:0] a_x, b_x, c_x, a_y, b_y, c_y;

  always #5 clk = ~clk;

  bayer_mosaic #(.width(4), .height(2), .pattern(0)) u_a (
    .clk, .reset, .iR, .iG, .iB, .iValid, .iReady(a_r), .tpgEn,
    .oData(a_d), .oValid(a_v), .oReady, .xCnt(a_x), .yCnt(a_y),
    .oDone(a_done));

  bayer_mosaic #(.width(2), .height(2), .pattern(2)) u_b (
    .clk, .reset, .iR, .iG, .iB, .iValid, .iReady(b_r), .tpgEn,
    .oData(b_d), .oValid(b_v), .oReady, .xCnt(b_x), .yCnt(b_y),
    .oDone(b_done));

`ifdef MOSAIC_TPG_EN
  bayer_mosaic #(.width(16), .height(1), .pattern(0)) u_c (
    .clk, .reset, .iR, .iG, .iB, .iValid, .iReady(c_r), .tpgEn,
    .oData(c_d), .oValid(c_v), .oReady, .xCnt(c_x), .yCnt(c_y),
    .oDone(c_done));
`else
  assign {c_d, c_v, c_r, c_done, c_x, c_y} = '0;
`endif

  int          sel = 0;
  logic [7:0]  m_d;
  logic        m_v, m_r, m_done;
  logic [31:0] m_x, m_y;

  always_comb begin
    {m_d, m_v, m_r, m_done, m_x, m_y} = {a_d, a_v, a_r, a_done, a_x, a_y};
    if (sel == 1)
      {m_d, m_v, m_r, m_done, m_x, m_y} = {b_d, b_v, b_r, b_done, b_x, b_y};
    else if (sel == 2)
      {m_d, m_v, m_r, m_done, m_x, m_y} = {c_d, c_v, c_r, c_done, c_x, c_y};
  end

  typedef struct {
    logic [7:0] d;
    int         x;
    int         y;
    bit         last;
  } exp_t;

  exp_t       q[$];
  logic [7:0] seen[$];
  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, acc_cnt = 0;
  int cur_w = 4, cur_h = 2, src_mode = 0, mx = 0, my = 0;
  int cur_pat = 0;
  bit mon_en = 1'b0, tpg_on = 1'b0;

  // 0=R 1=G 2=B, from the phase table indexed by {y[0],x[0]}.
  function automatic int ch_of(int p, int x, int y);
    int i;
    i = (y % 2) * 2 + (x % 2);
    case (p)
      0:       return (i == 1) ? 2 : (i == 2) ? 0 : 1;
      1:       return (i == 0) ? 2 : (i == 3) ? 0 : 1;
      2:       return (i == 0) ? 0 : (i == 3) ? 2 : 1;
      default: return (i == 1) ? 0 : (i == 2) ? 2 : 1;
    endcase
  endfunction

  task automatic src_px(input int x, input int y,
                        output logic [7:0] R, G, B);
    int k;
    if (src_mode == 0) begin
      R = 8'(x + 10 * y); G = 8'(100 + x); B = 8'(200 + y);
    end else if (src_mode == 1) begin
      R = 8'd1; G = 8'd2; B = 8'd3;
    end else begin
      k = (x / (cur_w / 8)) % 8;
      R = (k & 4) ? 8'd255 : 8'd0;
      G = (k & 2) ? 8'd255 : 8'd0;
      B = (k & 1) ? 8'd255 : 8'd0;
    end
  endtask

  task automatic step(input bit v, input bit r);
    logic [7:0] R, G, B;
    bit   acc;
    exp_t e;
    int   c;
    src_px(mx, my, R, G, B);
    iValid = v; oReady = r; iR = R; iG = G; iB = B;
    acc = (v || tpg_on) && (m_r === 1'b1);
    c = ch_of(cur_pat, mx, my);
    e.d = (c == 0) ? R : (c == 1) ? G : B;
    e.x = mx; e.y = my;
    e.last = (mx == cur_w - 1) && (my == cur_h - 1);
    @(posedge clk);
    if (acc) begin
      q.push_back(e);
      acc_cnt++;
      if (mx == cur_w - 1) begin
        mx = 0;
        my = (my == cur_h - 1) ? 0 : my + 1;
      end else mx++;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      n_chk++;
      if (m_v !== (q.size() > 0)) begin
        n_fail++;
        $display("FAIL occ_valid: got %b want %b", m_v, q.size() > 0);
      end
      n_chk++;
      if (m_r !== (q.size() < 2)) begin
        n_fail++;
        $display("FAIL iready: got %b want %b", m_r, q.size() < 2);
      end
      if (m_v === 1'b1 && oReady && q.size() > 0) begin
        e = q.pop_front();
        seen.push_back(m_d);
        n_chk++;
        if (m_d !== e.d || m_x !== 32'(e.x) || m_y !== 32'(e.y)) begin
          n_fail++;
          $display("FAIL pixel: got %0d@(%0d,%0d) want %0d@(%0d,%0d)",
                   m_d, m_x, m_y, e.d, e.x, e.y);
        end
        n_chk++;
        if (m_done !== e.last) begin
          n_fail++;
          $display("FAIL done: got %b want %b", m_done, e.last);
        end
      end else begin
        n_chk++;
        if (m_done !== 1'b0) begin
          n_fail++;
          $display("FAIL done_idle: got %b want 0", m_done);
        end
      end
      if (m_done === 1'b1) done_cnt++;
    end
  end

  task automatic start(input int s, input int w, input int h,
                       input int p, input int mode);
    mon_en = 1'b0; tpg_on = 1'b0;
    sel = s; cur_w = w; cur_h = h; cur_pat = p; src_mode = mode;
    reset = 1'b0;
    step(1'b0, 1'b1);
    q.delete(); seen.delete();
    mx = 0; my = 0; done_cnt = 0; acc_cnt = 0;
    reset = 1'b1; mon_en = 1'b1;
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && q.size() > 0; c++) step(1'b0, 1'b1);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d left want 0", q.size());
    end
  endtask

  task automatic check_frame8(input string nm);
    logic [7:0] ref8[8] = '{100, 200, 102, 200, 10, 101, 12, 103};
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (seen.size() <= i || seen[i] !== ref8[i]) begin
        n_fail++;
        $display("FAIL %s_seq[%0d]: got %0d want %0d", nm, i,
                 (seen.size() > i) ? seen[i] : 8'hxx, ref8[i]);
      end
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL %s_done_cnt: got %0d want 1", nm, done_cnt);
    end
  endtask

  task automatic test_reset();
    sel = 0; mon_en = 1'b0;
    reset = 1'b0;
    step(1'b1, 1'b1);
    n_chk++;
    if (a_d !== 8'd0 || a_v !== 1'b0 || a_r !== 1'b1 ||
        a_x !== 32'd0 || a_y !== 32'd0 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got d=%0d v=%b r=%b x=%0d y=%0d done=%b want 0 0 1 0 0 0",
               a_d, a_v, a_r, a_x, a_y, a_done);
    end
  endtask

  task automatic test_back_to_back();
    start(0, 4, 2, 0, 0);
    for (int c = 0; c < 40 && acc_cnt < 8; c++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    drain();
    check_frame8("b2b");
  endtask

  task automatic test_stall();
    int left = -1;
    logic [7:0] hd;
    logic [31:0] hx;
    start(0, 4, 2, 0, 0);
    for (int c = 0; c < 60 && acc_cnt < 8; c++) begin
      if (left < 0 && acc_cnt == 2) left = 3;
      if (left > 0) begin
        if (left == 3) begin
          hd = m_d; hx = m_x;
        end else begin
          n_chk++;
          if (m_d !== hd || m_x !== hx) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d/%0d want %0d/%0d",
                     m_d, m_x, hd, hx);
          end
        end
        step(1'b1, 1'b0);
        left--;
      end else step(1'b1, 1'b1);
    end
    drain();
    check_frame8("stall");
  endtask

  task automatic test_gaps();
    start(0, 4, 2, 0, 0);
    for (int c = 0; c < 60 && acc_cnt < 8; c++) step(c % 2 == 0, 1'b1);
    drain();
    check_frame8("gaps");
  endtask

  task automatic test_midreset();
    start(0, 4, 2, 0, 0);
    for (int c = 0; c < 40 && acc_cnt < 5; c++) step(1'b1, 1'b1);
    mon_en = 1'b0; reset = 1'b0;
    step(1'b0, 1'b1);
    q.delete(); seen.delete();
    mx = 0; my = 0; done_cnt = 0; acc_cnt = 0;
    n_chk++;
    if (a_d !== 8'd0 || a_v !== 1'b0 || a_r !== 1'b1 ||
        a_x !== 32'd0 || a_y !== 32'd0 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset: got d=%0d v=%b r=%b x=%0d y=%0d done=%b want 0 0 1 0 0 0",
               a_d, a_v, a_r, a_x, a_y, a_done);
    end
    reset = 1'b1; mon_en = 1'b1;
    for (int c = 0; c < 40 && acc_cnt < 8; c++) step(1'b1, 1'b1);
    drain();
    check_frame8("rst");
  endtask

  task automatic test_pattern2();
    logic [7:0] ref4[4] = '{1, 2, 2, 3};
    start(1, 2, 2, 2, 1);
    for (int c = 0; c < 40 && acc_cnt < 4; c++) step(1'b1, 1'b1);
    drain();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (seen.size() <= i || seen[i] !== ref4[i]) begin
        n_fail++;
        $display("FAIL pat2_seq[%0d]: got %0d want %0d", i,
                 (seen.size() > i) ? seen[i] : 8'hxx, ref4[i]);
      end
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL pat2_done_cnt: got %0d want 1", done_cnt);
    end
  endtask

`ifdef MOSAIC_TPG_EN
  task automatic test_tpg();
    logic [7:0] bars[16] = '{0, 0, 0, 255, 255, 0, 255, 255,
                             0, 0, 0, 255, 255, 0, 255, 255};
    start(2, 16, 1, 0, 2);
    tpgEn = 1'b1; tpg_on = 1'b1;
    for (int c = 0; c < 100 && seen.size() < 16; c++) step(1'b0, 1'b1);
    mon_en = 1'b0; tpg_on = 1'b0; tpgEn = 1'b0;
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (seen.size() <= i || seen[i] !== bars[i]) begin
        n_fail++;
        $display("FAIL tpg_seq[%0d]: got %0d want %0d", i,
                 (seen.size() > i) ? seen[i] : 8'hxx, bars[i]);
      end
    end
    n_chk++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL tpg_done_cnt: got %0d want 1", done_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_gaps();
    test_midreset();
    test_pattern2();
`ifdef MOSAIC_TPG_EN
    test_tpg();
`endif
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
